// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and defaults for the one-shot timer channels
package timer_pkg;

    localparam int TIMER_DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;
    localparam logic [1:0] ST_EXPIRED = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RUN     = ST_RUN,
        PAUSED  = ST_PAUSED,
        EXPIRED = ST_EXPIRED
    } timer_state_e;

endpackage

// File: rtl/oneshot_timer_channel.sv
// rtl/oneshot_timer_channel.sv - single saturating one-shot timer: FSM plus counter, advanced by tick
module oneshot_timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             expired_pulse
);

    timer_state_e     state, state_next;
    logic [WIDTH-1:0] thr, thr_next;
    logic [WIDTH-1:0] count_next, count_inc;
    logic             pulse_next, running_next, expired_next;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state         <= IDLE;
            thr           <= '0;
            count         <= '0;
            running       <= 1'b0;
            expired       <= 1'b0;
            expired_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            thr           <= thr_next;
            count         <= count_next;
            running       <= running_next;
            expired       <= expired_next;
            expired_pulse <= pulse_next;
        end
    end

    // count stays strictly below thr in RUN, so the increment cannot wrap
    assign count_inc = count + 1'b1;

    always_comb begin
        state_next = state;
        thr_next   = thr;
        count_next = count;
        pulse_next = 1'b0;
        if (abort) begin
            state_next = IDLE;
            count_next = '0;
        end else if (start) begin
            thr_next   = threshold;
            count_next = '0;
            if (threshold == '0) begin
                state_next = EXPIRED;
                pulse_next = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (tick) begin
                        count_next = count_inc;
                        if (count_inc == thr) begin
                            state_next = EXPIRED;
                            pulse_next = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) state_next = RUN;
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        running_next = (state_next == RUN) || (state_next == PAUSED);
        expired_next = (state_next == EXPIRED);
    end

endmodule

// File: rtl/multi_channel_oneshot_timer.sv
// rtl/multi_channel_oneshot_timer.sv - NUM_CH independent one-shot timers; TIMER_PRESCALE_EN adds a shared tick prescaler
module multi_channel_oneshot_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = TIMER_DEFAULT_WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       pause,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH*WIDTH-1:0] threshold,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       expired_pulse
);

    logic tick;

`ifdef TIMER_PRESCALE_EN
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int             PS_W    = $clog2(PRESCALE);
            localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

            // free-running; commands never resynchronise it
            logic [PS_W-1:0] ps_cnt;

            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n)               ps_cnt <= '0;
                else if (ps_cnt == PS_LAST) ps_cnt <= '0;
                else                        ps_cnt <= ps_cnt + 1'b1;
            end

            assign tick = (ps_cnt == PS_LAST);
        end else begin : g_no_prescale
            assign tick = 1'b1;
        end
    endgenerate
`else
    assign tick = 1'b1;
`endif

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            oneshot_timer_channel #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clock         (clock),
                .clear_n       (clear_n),
                .tick          (tick),
                .start         (start[i]),
                .pause         (pause[i]),
                .abort         (abort[i]),
                .threshold     (threshold[i*WIDTH +: WIDTH]),
                .count         (count[i*WIDTH +: WIDTH]),
                .running       (running[i]),
                .expired       (expired[i]),
                .expired_pulse (expired_pulse[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_oneshot_timer.sv
// tb/tb_multi_channel_oneshot_timer.sv - directed self-checking bench for multi_channel_oneshot_timer
module tb_multi_channel_oneshot_timer;

    localparam int NUM_CH   = 2;
    localparam int WIDTH    = 8;
    localparam int PRESCALE = 4;

    logic                    clock;
    logic                    clear_n;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       pause;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH*WIDTH-1:0] threshold;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       running;
    logic [NUM_CH-1:0]       expired;
    logic [NUM_CH-1:0]       expired_pulse;

    int checks   = 0;
    int failures = 0;

    multi_channel_oneshot_timer #(
        .NUM_CH   (NUM_CH),
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clock         (clock),
        .clear_n       (clear_n),
        .start         (start),
        .pause         (pause),
        .abort         (abort),
        .threshold     (threshold),
        .count         (count),
        .running       (running),
        .expired       (expired),
        .expired_pulse (expired_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input int ch, input logic [WIDTH-1:0] c,
                          input logic r, input logic e, input logic p);
        chk({tag, "_count"},   32'(count[ch*WIDTH +: WIDTH]), 32'(c));
        chk({tag, "_running"}, 32'(running[ch]),              32'(r));
        chk({tag, "_expired"}, 32'(expired[ch]),              32'(e));
        chk({tag, "_pulse"},   32'(expired_pulse[ch]),        32'(p));
    endtask

    initial begin
        clear_n   = 1'b0;
        start     = '0;
        pause     = '0;
        abort     = '0;
        threshold = '0;
        step();
        step();
        chk_ch("reset_ch0", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk_ch("reset_ch1", 1, 8'd0, 1'b0, 1'b0, 1'b0);
        clear_n = 1'b1;
        step();
        chk_ch("post_reset_ch0", 0, 8'd0, 1'b0, 1'b0, 1'b0);

`ifdef TIMER_PRESCALE_EN
        begin
            int e1 = -1;
            int e2 = -1;
            threshold[7:0] = 8'd2;
            start[0] = 1'b1;
            step();
            start[0] = 1'b0;
            chk_ch("ps_start", 0, 8'd0, 1'b1, 1'b0, 1'b0);
            for (int n = 1; n <= 20; n++) begin
                step();
                if (e1 < 0 && count[7:0] == 8'd1) e1 = n;
                if (e2 < 0 && count[7:0] == 8'd2) e2 = n;
            end
            chk("ps_tick_spacing", 32'(e2 - e1), 32'd4);
            chk("ps_expiry_in_window", 32'((e2 >= 5) && (e2 <= 11)), 32'd1);
            chk("ps_expired", 32'(expired[0]), 32'd1);
        end
`else
        // basic expiry, threshold changed after start must be ignored
        threshold[7:0] = 8'd4;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        threshold[7:0] = 8'd100;
        chk_ch("basic_c0", 0, 8'd0, 1'b1, 1'b0, 1'b0);
        step(); chk_ch("basic_c1", 0, 8'd1, 1'b1, 1'b0, 1'b0);
        step(); chk_ch("basic_c2", 0, 8'd2, 1'b1, 1'b0, 1'b0);
        step(); chk_ch("basic_c3", 0, 8'd3, 1'b1, 1'b0, 1'b0);
        step(); chk_ch("basic_exp", 0, 8'd4, 1'b0, 1'b1, 1'b1);
        step(); chk_ch("basic_pulse_drop", 0, 8'd4, 1'b0, 1'b1, 1'b0);
        repeat (20) step();
        chk_ch("basic_hold", 0, 8'd4, 1'b0, 1'b1, 1'b0);

        // pause on ch1 at count 2; transition edges consume no tick
        threshold[15:8] = 8'd6;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        step();
        step(); chk_ch("pause_pre", 1, 8'd2, 1'b1, 1'b0, 1'b0);
        pause[1] = 1'b1;
        step(); chk_ch("pause_enter", 1, 8'd2, 1'b1, 1'b0, 1'b0);
        step();
        step(); chk_ch("pause_hold", 1, 8'd2, 1'b1, 1'b0, 1'b0);
        pause[1] = 1'b0;
        step(); chk_ch("pause_exit", 1, 8'd2, 1'b1, 1'b0, 1'b0);
        step(); chk_ch("pause_resume", 1, 8'd3, 1'b1, 1'b0, 1'b0);
        step();
        step(); chk_ch("pause_c5", 1, 8'd5, 1'b1, 1'b0, 1'b0);
        step(); chk_ch("pause_exp", 1, 8'd6, 1'b0, 1'b1, 1'b1);

        // abort wins over start
        threshold[15:8] = 8'd5;
        start[1] = 1'b1;
        abort[1] = 1'b1;
        step();
        start[1] = 1'b0;
        abort[1] = 1'b0;
        chk_ch("abort_start", 1, 8'd0, 1'b0, 1'b0, 1'b0);
        step(); chk_ch("abort_idle", 1, 8'd0, 1'b0, 1'b0, 1'b0);

        // zero threshold expires on the start edge
        threshold[7:0] = 8'd0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk_ch("t0_exp", 0, 8'd0, 1'b0, 1'b1, 1'b1);
        step(); chk_ch("t0_pulse_once", 0, 8'd0, 1'b0, 1'b1, 1'b0);

        // maximum threshold, no wrap
        threshold[15:8] = 8'd255;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        repeat (254) step();
        chk_ch("max_254", 1, 8'd254, 1'b1, 1'b0, 1'b0);
        step(); chk_ch("max_exp", 1, 8'd255, 1'b0, 1'b1, 1'b1);
        repeat (5) step();
        chk_ch("max_hold", 1, 8'd255, 1'b0, 1'b1, 1'b0);

        // restart from EXPIRED
        threshold[15:8] = 8'd3;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        chk_ch("restart_c0", 1, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        step(); chk_ch("restart_c2", 1, 8'd2, 1'b1, 1'b0, 1'b0);
        step(); chk_ch("restart_exp", 1, 8'd3, 1'b0, 1'b1, 1'b1);

        // independence: both start, ch1 aborted at count 1
        threshold = {8'd3, 8'd3};
        start = 2'b11;
        step();
        start = 2'b00;
        step();
        chk_ch("ind_ch0_c1", 0, 8'd1, 1'b1, 1'b0, 1'b0);
        chk_ch("ind_ch1_c1", 1, 8'd1, 1'b1, 1'b0, 1'b0);
        abort[1] = 1'b1;
        step();
        abort[1] = 1'b0;
        chk_ch("ind_ch0_c2", 0, 8'd2, 1'b1, 1'b0, 1'b0);
        chk_ch("ind_ch1_abort", 1, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_ch("ind_ch0_exp", 0, 8'd3, 1'b0, 1'b1, 1'b1);
        chk_ch("ind_ch1_idle", 1, 8'd0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-run
        threshold[7:0] = 8'd9;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (5) step();
        chk_ch("rst_pre", 0, 8'd5, 1'b1, 1'b0, 1'b0);
        clear_n = 1'b0;
        #2;
        chk_ch("rst_async", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        #1;
        clear_n = 1'b1;
        step();
        chk_ch("rst_release_ch0", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk_ch("rst_release_ch1", 1, 8'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
